axi_rd_arbiter: RTL and testbench
=================================

// Module: axi_rd_arbiter
// PURPOSE
// - Shares one AXI4 read master (AR+R) between NUM_M DMA read engines: M0 = BSR weight DMA, M1 = activation DMA.
// - Arbitrates AR round-robin, stamps each burst with its port's ID and returns R beats to the owner by RID.
// - Caps outstanding bursts per port. Sits between the DMA engines and the AXI bridge.
// PARAMETERS
// AXI_ADDR_W   32   address width
// AXI_DATA_W   64   data width
// AXI_ID_W     4    ID width
// NUM_M        2    requester ports (2..4)
// PORT_IDS     {4'd1,4'd0}  packed per-port ARID; port i uses PORT_IDS[i*AXI_ID_W +: AXI_ID_W]
// MAX_OUTST    4    max outstanding bursts per port (>=1)
// PORTS  (s_* packed as NUM_M slices, slice i = port i)
// clk            in   1              clock
// rst_n          in   1              asynchronous active-low reset
// s_araddr       in   NUM_M*ADDR_W   per-port AR address
// s_arlen        in   NUM_M*8        per-port AR length
// s_arsize       in   NUM_M*3        per-port AR size
// s_arburst      in   NUM_M*2        per-port AR burst type
// s_arvalid      in   NUM_M          per-port AR valid
// s_arready      out  NUM_M          per-port AR ready
// s_rid/s_rdata/s_rresp/s_rlast  out  ID_W/DATA_W/2/1  R payload broadcast to all ports
// s_rvalid       out  NUM_M          per-port R valid
// s_rready       in   NUM_M          per-port R ready
// m_arid/m_araddr/m_arlen/m_arsize/m_arburst  out  ID_W/ADDR_W/8/3/2  registered AR to bridge
// m_arvalid      out  1              AR valid to bridge
// m_arready      in   1              AR ready from bridge
// m_rid/m_rdata/m_rresp/m_rlast/m_rvalid  in  ID_W/DATA_W/2/1/1  R from bridge
// m_rready       out  1              R ready to bridge
// err_unknown_id out  1              sticky: beat whose RID matches no port
// err_underflow  out  1              sticky: RLAST received with zero outstanding for that port
// outst_cnt      out  NUM_M*$clog2(MAX_OUTST+1)  per-port outstanding-burst count
// BEHAVIOUR
// - Reset: m_arvalid=0, s_arready=0, all m_ar* payload=0, outst_cnt=0, err_*=0, rr pointer=port 0.
// - AR FSM, 2 states:
//   - IDLE: eligible(i) = s_arvalid[i] && outst_cnt[i]<MAX_OUTST; choose first eligible at or after rr pointer.
//     On a grant: s_arready[g]=1 for exactly one cycle; latch payload and m_arid=PORT_IDS[g]; m_arvalid<=1; -> ISSUE.
//   - ISSUE: hold m_ar* stable with m_arvalid=1 until m_arready. On handshake: m_arvalid<=0, outst_cnt[g]++, rr<=g+1 (mod NUM_M), -> IDLE.
//   - Latency: AR accept to m_arvalid is 1 cycle. Max issue rate is one burst per 2 cycles.
//   - s_arready is 0 in ISSUE, so a port's arvalid/payload must stay stable until its own s_arready.
// - R path, combinational, no added latency:
//   - hit[i] = m_rvalid && m_rid==PORT_IDS[i]; s_rvalid[i]=hit[i]; m_rready = s_rready[hit port].
//   - No port hit: m_rready=1 (beat dropped) and err_unknown_id<=1.
//   - On m_rvalid&&m_rready&&m_rlast for hit port p: outst_cnt[p]--. If it was already 0: stays 0, err_underflow<=1.
// - Same cycle as AR handshake and RLAST on one port: count net unchanged; both updates apply, never lost.
// - Port at MAX_OUTST: masked from arbitration only; its R beats still flow.
// - rresp passes through unmodified. Error handling is the DMA's job.
// - Errors clear only on reset.
// - Reset mid-burst: all state returns to reset values; the system resets the bridge on the same rst_n.
// - Duplicate entries in PORT_IDS are illegal: assert at elaboration.
// STRUCTURE
// - Shared package (dma_pkg): AXI_SIZE_64, AXI_BURST_INCR, RESP_OKAY, arb_state_t {ARB_IDLE, ARB_ISSUE}.
//   The DMA engines import the same package.
// - One sub-module: rr_arbiter #(N) (req, ptr -> one-hot gnt, combinational), reusable for a write-side arbiter.
// - Outstanding counters, R demux and AR register stay in this module.
// TESTING
// 1) Only M1 requests araddr=0x1000, arlen=15, bridge arready same cycle
//    -> m_arid=1, m_araddr=0x1000, m_arlen=15; 16 beats rid=1 reach s_rvalid[1] only; outst_cnt[1] 0->1->0.
// 2) M0 and M1 arvalid together for 4 bursts each
//    -> m_arid sequence 0,1,0,1,0,1,0,1; no port starved.
// 3) Bridge withholds m_arready 5 cycles
//    -> m_ar* constant and m_arvalid=1 throughout; no second s_arready pulse.
// 4) MAX_OUTST=4, M1 issues 5 bursts with no R returned
//    -> 5th not granted (s_arready[1]=0) until one RLAST on rid=1, then granted next IDLE cycle.
// 5) Beat with rid=7 -> m_rready=1, no s_rvalid, err_unknown_id=1 and sticky.
//    RLAST rid=0 with outst_cnt[0]=0 -> err_underflow=1.
// 6) rst_n low during beat 8 of a 16-beat burst
//    -> all outputs at reset values asynchronously; after release, a new burst from M0 completes normally.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared AXI read-side definitions used by the read arbiter and the DMA engines.
package dma_pkg;
  localparam logic [2:0] AXI_SIZE_64    = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

  typedef enum logic {ARB_IDLE, ARB_ISSUE} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins (one-hot grant).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  always_comb begin
    int  idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between NUM_M DMA engines: round-robin AR, ID-routed R,
// per-port outstanding-burst caps.
module axi_rd_arbiter import dma_pkg::*; #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W   = 4,
  parameter int NUM_M      = 2,
  parameter logic [NUM_M*AXI_ID_W-1:0] PORT_IDS = {4'd1, 4'd0},
  parameter int MAX_OUTST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_M*AXI_ADDR_W-1:0]   s_araddr,
  input  logic [NUM_M*8-1:0]            s_arlen,
  input  logic [NUM_M*3-1:0]            s_arsize,
  input  logic [NUM_M*2-1:0]            s_arburst,
  input  logic [NUM_M-1:0]              s_arvalid,
  output logic [NUM_M-1:0]              s_arready,
  output logic [AXI_ID_W-1:0]           s_rid,
  output logic [AXI_DATA_W-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic                          s_rlast,
  output logic [NUM_M-1:0]              s_rvalid,
  input  logic [NUM_M-1:0]              s_rready,
  output logic [AXI_ID_W-1:0]           m_arid,
  output logic [AXI_ADDR_W-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [AXI_ID_W-1:0]           m_rid,
  input  logic [AXI_DATA_W-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic                          err_unknown_id,
  output logic                          err_underflow,
  output logic [NUM_M*$clog2(MAX_OUTST+1)-1:0] outst_cnt
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = $clog2(NUM_M);

  if (NUM_M < 2 || NUM_M > 4) begin : g_bad_num_m
    $error("axi_rd_arbiter: NUM_M must be 2..4");
  end
  for (genvar a = 0; a < NUM_M; a++) begin : g_id_a
    for (genvar b = a + 1; b < NUM_M; b++) begin : g_id_b
      if (PORT_IDS[a*AXI_ID_W +: AXI_ID_W] == PORT_IDS[b*AXI_ID_W +: AXI_ID_W]) begin : g_dup
        $error("axi_rd_arbiter: duplicate entry in PORT_IDS");
      end
    end
  end

  arb_state_t                    state_q, state_d;
  logic [PTR_W-1:0]              rr_q, gnt_q, gnt_idx;
  logic                          run_q, grant, ar_hs, any_hit;
  logic [NUM_M-1:0]              elig, gnt_oh, hit, inc, dec;
  logic [NUM_M-1:0][CNT_W-1:0]   cnt_q;

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign elig[i] = s_arvalid[i] && (cnt_q[i] < CNT_W'(MAX_OUTST));
    assign hit[i]  = m_rvalid && (m_rid == PORT_IDS[i*AXI_ID_W +: AXI_ID_W]);
    assign inc[i]  = ar_hs && (gnt_q == PTR_W'(i));
    assign dec[i]  = hit[i] && m_rready && m_rlast;
  end

  rr_arbiter #(.N(NUM_M), .PW(PTR_W)) u_rr (.req(elig), .ptr(rr_q), .gnt(gnt_oh));

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_M; i++)
      if (gnt_oh[i]) gnt_idx = PTR_W'(i);
  end

  // run_q keeps s_arready low while reset is held and for the first edge after release
  assign grant     = run_q && (state_q == ARB_IDLE) && (|gnt_oh);
  assign s_arready = grant ? gnt_oh : '0;
  assign ar_hs     = (state_q == ARB_ISSUE) && m_arready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (grant) state_d = ARB_ISSUE;
      ARB_ISSUE: if (m_arready) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      run_q     <= 1'b0;
      rr_q      <= '0;
      gnt_q     <= '0;
      m_arvalid <= 1'b0;
      m_arid    <= '0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (grant) begin
        gnt_q     <= gnt_idx;
        m_arvalid <= 1'b1;
        m_arid    <= PORT_IDS[gnt_idx*AXI_ID_W +: AXI_ID_W];
        m_araddr  <= s_araddr[gnt_idx*AXI_ADDR_W +: AXI_ADDR_W];
        m_arlen   <= s_arlen[gnt_idx*8 +: 8];
        m_arsize  <= s_arsize[gnt_idx*3 +: 3];
        m_arburst <= s_arburst[gnt_idx*2 +: 2];
      end else if (ar_hs) begin
        m_arvalid <= 1'b0;
        rr_q      <= (gnt_q == PTR_W'(NUM_M - 1)) ? '0 : gnt_q + 1'b1;
      end
    end
  end

  // R path is pure routing; unknown IDs are sunk so the bridge never stalls on them
  assign any_hit  = |hit;
  assign m_rready = any_hit ? |(hit & s_rready) : 1'b1;
  assign s_rvalid = hit;
  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;

  // inc and dec on the same port in one cycle cancel; a dec at zero saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      err_unknown_id <= 1'b0;
      err_underflow  <= 1'b0;
    end else begin
      if (m_rvalid && !any_hit) err_unknown_id <= 1'b1;
      for (int i = 0; i < NUM_M; i++) begin
        if (dec[i] && cnt_q[i] == '0) err_underflow <= 1'b1;
        cnt_q[i] <= cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i] && cnt_q[i] != '0);
      end
    end
  end

  assign outst_cnt = cnt_q;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: AR/R scoreboards plus table-driven R-routing vectors.
module tb_axi_rd_arbiter;
  import dma_pkg::*;
  localparam int AW = 32, DW = 64, IW = 4, NM = 2, MO = 4;
  localparam int CW = $clog2(MO + 1);
  localparam logic [NM*IW-1:0] PIDS = {4'd1, 4'd0};

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM*AW-1:0] s_araddr = '0;
  logic [NM*8-1:0]  s_arlen = '0;
  logic [NM*3-1:0]  s_arsize = '0;
  logic [NM*2-1:0]  s_arburst = '0;
  logic [NM-1:0]    s_arvalid = '0, s_arready, s_rvalid, s_rready = '1;
  logic [IW-1:0]    s_rid, m_arid, m_rid = '0;
  logic [DW-1:0]    s_rdata, m_rdata = '0;
  logic [1:0]       s_rresp, m_arburst, m_rresp = '0;
  logic             s_rlast, m_arvalid, m_arready = 1'b0, m_rlast = 1'b0, m_rvalid = 1'b0, m_rready;
  logic [AW-1:0]    m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic             err_unknown_id, err_underflow;
  logic [NM*CW-1:0] outst_cnt;

  axi_rd_arbiter #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .NUM_M(NM),
                   .PORT_IDS(PIDS), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .err_unknown_id(err_unknown_id),
    .err_underflow(err_underflow), .outst_cnt(outst_cnt));

  int errors = 0, checks = 0;
  logic [IW+AW-1:0] ar_q[$];
  logic [NM-1:0]    r_q[$];

  typedef struct {
    logic [IW-1:0] rid;
    logic [NM-1:0] rready;
    logic [NM-1:0] exp_rvalid;
    logic          exp_mrready;
  } rvec_t;
  rvec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int p);
    return outst_cnt[p*CW +: CW];
  endfunction

  function automatic logic [IW-1:0] pid(input int p);
    return PIDS[p*IW +: IW];
  endfunction

  // AR scoreboard: every bridge handshake must match the next expected {id, addr}
  always @(negedge clk) begin
    if (rst_n && m_arvalid && m_arready) begin
      if (ar_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ar_unexpected: got id=%0h addr=%0h, none expected", m_arid, m_araddr);
      end else check("ar_hs", {m_arid, m_araddr}, ar_q.pop_front());
    end
  end

  // R scoreboard: each accepted beat must route to the expected port with payload intact
  always @(negedge clk) begin
    if (rst_n && m_rvalid && m_rready) begin
      if (r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected: beat rid=%0h accepted, none expected", m_rid);
      end else begin
        check("s_rvalid", s_rvalid, r_q.pop_front());
        check("s_rdata", s_rdata, m_rdata);
      end
    end
  end

  task automatic set_ar(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
    s_araddr[p*AW +: AW] = addr;
    s_arlen[p*8 +: 8]    = len;
    s_arsize[p*3 +: 3]   = AXI_SIZE_64;
    s_arburst[p*2 +: 2]  = AXI_BURST_INCR;
  endtask

  task automatic send_ar(input int p, input logic [AW-1:0] addr, input logic [7:0] len);
    bit ok = 0;
    set_ar(p, addr, len);
    s_arvalid[p] = 1'b1;
    for (int c = 0; c < 30 && !ok; c++) begin
      #1;
      if (s_arready[p]) begin
        ok = 1;
        ar_q.push_back({pid(p), addr});
      end
      @(posedge clk); #1;
    end
    s_arvalid[p] = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ar_grant_timeout: port %0d never got s_arready", p);
    end
  endtask

  task automatic r_beat(input logic [IW-1:0] rid, input logic last, input logic [NM-1:0] exp);
    m_rvalid = 1'b1; m_rid = rid; m_rlast = last; m_rresp = RESP_OKAY;
    m_rdata  = {$urandom, $urandom};
    r_q.push_back(exp);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic drain(input int p, input int n);
    for (int k = 0; k < n; k++) r_beat(pid(p), 1'b1, NM'(1) << p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    logic [NM-1:0] g;
    tbl[0] = '{4'd0, 2'b11, 2'b01, 1'b1};
    tbl[1] = '{4'd1, 2'b11, 2'b10, 1'b1};
    tbl[2] = '{4'd0, 2'b10, 2'b01, 1'b0};
    tbl[3] = '{4'd1, 2'b01, 2'b10, 1'b0};
    tbl[4] = '{4'd7, 2'b00, 2'b00, 1'b1};
    tbl[5] = '{4'd3, 2'b11, 2'b00, 1'b1};

    // reset state
    #2;
    check("rst_m_arvalid", m_arvalid, 0);
    check("rst_s_arready", s_arready, 0);
    check("rst_outst", outst_cnt, 0);
    check("rst_errs", {err_unknown_id, err_underflow}, 0);
    check("rst_m_ar", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1) single burst from M1
    m_arready = 1'b1;
    send_ar(1, 32'h1000, 8'd15);
    check("t1_arvalid", m_arvalid, 1);
    check("t1_arid", m_arid, 1);
    check("t1_araddr", m_araddr, 32'h1000);
    check("t1_arlen", m_arlen, 15);
    check("t1_cnt_pre", cnt(1), 0);
    @(posedge clk); #1;
    check("t1_cnt_issued", cnt(1), 1);
    check("t1_arvalid_drop", m_arvalid, 0);
    for (int b = 0; b < 16; b++) r_beat(4'd1, b == 15, 2'b10);
    check("t1_cnt_done", cnt(1), 0);

    // 2) both ports contend: strict alternation starting at port 0
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 2; p++) ar_q.push_back({pid(p), 32'h2000 + p*32'h100 + k*32'h10});
    n0 = 0; n1 = 0;
    set_ar(0, 32'h2000, 8'd0); set_ar(1, 32'h2100, 8'd0);
    s_arvalid = 2'b11;
    for (int c = 0; c < 40 && (n0 < 4 || n1 < 4); c++) begin
      #1; g = s_arvalid & s_arready;
      @(posedge clk); #1;
      if (g[0]) begin n0++; set_ar(0, 32'h2000 + n0*32'h10, 8'd0); if (n0 == 4) s_arvalid[0] = 1'b0; end
      if (g[1]) begin n1++; set_ar(1, 32'h2100 + n1*32'h10, 8'd0); if (n1 == 4) s_arvalid[1] = 1'b0; end
    end
    s_arvalid = '0;
    check("t2_grants_p0", n0, 4);
    check("t2_grants_p1", n1, 4);
    @(posedge clk); #1; @(posedge clk); #1;
    check("t2_ar_all_issued", ar_q.size(), 0);
    check("t2_cnt", outst_cnt, {CW'(4), CW'(4)});
    drain(0, 4); drain(1, 4);
    check("t2_cnt_drained", outst_cnt, 0);

    // 3) bridge stalls 5 cycles; payload held, no grant to the waiting port
    m_arready = 1'b0;
    send_ar(0, 32'h3000, 8'd7);
    set_ar(1, 32'h3100, 8'd3);
    s_arvalid[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("t3_arvalid_held", m_arvalid, 1);
      check("t3_ar_stable", {m_arid, m_araddr, m_arlen}, {4'd0, 32'h3000, 8'd7});
      check("t3_no_grant", s_arready, 0);
      @(posedge clk); #1;
    end
    m_arready = 1'b1;
    @(posedge clk); #1; #1;
    check("t3_next_grant", s_arready, 2'b10);
    ar_q.push_back({pid(1), 32'h3100});
    @(posedge clk); #1;
    s_arvalid[1] = 1'b0;
    @(posedge clk); #1;
    drain(0, 1); drain(1, 1);
    check("t3_cnt", outst_cnt, 0);

    // 4) cap at MAX_OUTST: fifth burst waits for one RLAST
    for (int k = 0; k < 4; k++) send_ar(1, 32'h4000 + k*32'h40, 8'd1);
    set_ar(1, 32'h4100, 8'd1);
    s_arvalid[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1; #1;
      check("t4_capped", s_arready[1], 0);
    end
    check("t4_cnt_max", cnt(1), 4);
    r_beat(4'd1, 1'b1, 2'b10);
    #1;
    check("t4_grant_after_rlast", s_arready[1], 1);
    ar_q.push_back({pid(1), 32'h4100});
    @(posedge clk); #1;
    s_arvalid[1] = 1'b0;
    @(posedge clk); #1;
    check("t4_cnt_refill", cnt(1), 4);
    drain(1, 4);

    // same-cycle AR handshake and RLAST on port 0 must net out
    send_ar(0, 32'h5000, 8'd0);
    @(posedge clk); #1;
    m_arready = 1'b0;
    send_ar(0, 32'h5040, 8'd0);
    check("t4_pre_overlap", cnt(0), 1);
    m_arready = 1'b1;
    r_beat(4'd0, 1'b1, 2'b01);
    check("t4_overlap_net", cnt(0), 1);
    drain(0, 1);
    check("t4_overlap_drained", outst_cnt, 0);

    // 5) R routing table, unknown IDs, underflow
    check("t5_unknown_clear", err_unknown_id, 0);
    for (int v = 0; v < 6; v++) begin
      m_rvalid = 1'b1; m_rid = tbl[v].rid; m_rlast = 1'b0; s_rready = tbl[v].rready;
      m_rdata = {$urandom, $urandom};
      if (tbl[v].exp_mrready) r_q.push_back(tbl[v].exp_rvalid);
      #1;
      check("t5_vec_rvalid", s_rvalid, tbl[v].exp_rvalid);
      check("t5_vec_mrready", m_rready, tbl[v].exp_mrready);
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; s_rready = '1;
    @(posedge clk); #1; @(posedge clk); #1;
    check("t5_unknown_sticky", err_unknown_id, 1);
    check("t5_underflow_clear", err_underflow, 0);
    r_beat(4'd0, 1'b1, 2'b01);
    check("t5_underflow_set", err_underflow, 1);
    check("t5_underflow_cnt", cnt(0), 0);

    // 6) async reset during beat 8 of a 16-beat burst, then recover
    send_ar(0, 32'h8000, 8'd15);
    @(posedge clk); #1;
    for (int b = 0; b < 7; b++) r_beat(4'd0, 1'b0, 2'b01);
    m_rvalid = 1'b1; m_rid = 4'd0;
    #2; rst_n = 1'b0; m_rvalid = 1'b0;
    #1;
    check("t6_rst_arvalid", m_arvalid, 0);
    check("t6_rst_arready", s_arready, 0);
    check("t6_rst_cnt", outst_cnt, 0);
    check("t6_rst_errs", {err_unknown_id, err_underflow}, 0);
    check("t6_rst_m_ar", {m_arid, m_araddr, m_arlen}, 0);
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_ar(0, 32'h9000, 8'd3);
    @(posedge clk); #1;
    check("t6_cnt_new", cnt(0), 1);
    for (int b = 0; b < 4; b++) r_beat(4'd0, b == 3, 2'b01);
    check("t6_cnt_done", outst_cnt, 0);
    check("t6_errs_clean", {err_unknown_id, err_underflow}, 0);
    check("end_ar_q_empty", ar_q.size(), 0);
    check("end_r_q_empty", r_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
